// File: rtl/seg7_disp_sched.sv
// seg7_disp_sched: round-robin owner scheduler for the shared 8-digit
// seven-segment display driver. One requester at a time is granted for a
// minimum dwell period, after which ownership rotates to the next requester.
// All display-facing outputs are registered.
//
// Optional build macro: SEG7_SCHED_GAP_EN inserts GAP_CYC blank cycles
// between owners. The default build (macro undefined) switches owners directly.
module seg7_disp_sched #(
  parameter int NSRC    = 4,
  parameter int DWELL   = 10_000_000,
  parameter int DWELL_W = 24,
  parameter int GAP_CYC = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NSRC-1:0]           req,
  input  logic [NSRC-1:0]           src_mode,
  input  logic [NSRC*64-1:0]        src_data,
  input  logic                      hold,
  output logic [NSRC-1:0]           grant,
  output logic [$clog2(NSRC)-1:0]   cur_src,
  output logic                      disp_mode,
  output logic [63:0]               disp_data,
  output logic                      switch_pulse
);

  localparam int          IW    = $clog2(NSRC);
  localparam logic [63:0] BLANK = '1;  // segments are active-low

  // Reject parameter sets the counters and arbiter cannot represent.
  if (NSRC < 2 || NSRC > 8 || DWELL < 1 || GAP_CYC < 1 ||
      ((DWELL - 1) >> DWELL_W) != 0) begin : g_bad_param
    $error("seg7_disp_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Next index modulo NSRC.
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] idx);
    return (idx == IW'(NSRC - 1)) ? '0 : idx + 1'b1;
  endfunction

  // First requester found searching start, start+1, ... with wrap.
  function automatic logic [IW-1:0] pick(input logic [NSRC-1:0] r,
                                         input logic [IW-1:0]   start);
    logic [IW-1:0] res;
    logic [IW-1:0] j;
    res = '0;
    // Walk backwards so the lowest offset from start wins.
    for (int i = NSRC - 1; i >= 0; i--) begin
      j = IW'((int'(start) + i) % NSRC);
      if (r[j]) res = j;
    end
    return res;
  endfunction

  function automatic logic [NSRC-1:0] onehot(input logic [IW-1:0] idx);
    logic [NSRC-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  state_t               state, state_n;
  logic [IW-1:0]        rr_ptr, rr_n;
  logic [IW-1:0]        cur_n;
  logic [NSRC-1:0]      grant_n;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_n;
  logic                 pulse_n;
  logic                 mode_n;
  logic [63:0]          data_n;
  logic                 take;
  logic [IW-1:0]        tgt;
  logic                 owner_req, others_req, do_switch;
  logic [IW-1:0]        nxt_src;

`ifdef SEG7_SCHED_GAP_EN
  localparam int GW = $clog2(GAP_CYC + 1);
  logic [GW-1:0]        gap_cnt, gap_n;
`endif

  assign owner_req  = req[cur_src];
  assign others_req = |(req & ~onehot(cur_src));
  assign nxt_src    = pick(req, inc(cur_src));

  // Next-state and next-output decode; a new grant is committed in one place.
  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    cur_n    = cur_src;
    grant_n  = grant;
    rr_n     = rr_ptr;
    dwell_n  = (dwell_cnt != '0) ? dwell_cnt - DWELL_W'(1) : '0;
    pulse_n  = 1'b0;
    mode_n   = 1'b1;
    data_n   = BLANK;
    take     = 1'b0;
    tgt      = '0;
    do_switch = 1'b0;
`ifdef SEG7_SCHED_GAP_EN
    gap_n    = gap_cnt;
`endif

    case (state)
      S_IDLE: begin
        grant_n = '0;
        if (|req) begin
          take = 1'b1;
          tgt  = pick(req, rr_ptr);
        end
      end

      S_SHOW: begin
        mode_n    = src_mode[cur_src];
        data_n    = src_data[{cur_src, 6'd0} +: 64];
        // Owner loss always forces a move; expiry moves only when released.
        do_switch = (!owner_req && |req) ||
                    (owner_req && dwell_cnt == '0 && !hold && others_req);
        if (!(|req)) begin
          state_n = S_IDLE;
          grant_n = '0;
          mode_n  = 1'b1;
          data_n  = BLANK;
        end else if (do_switch) begin
`ifdef SEG7_SCHED_GAP_EN
          // Next owner is fixed now; cur_src carries it through the gap.
          state_n = S_GAP;
          grant_n = '0;
          cur_n   = nxt_src;
          gap_n   = GW'(GAP_CYC - 1);
          mode_n  = 1'b1;
          data_n  = BLANK;
`else
          take = 1'b1;
          tgt  = nxt_src;
`endif
        end
      end

`ifdef SEG7_SCHED_GAP_EN
      S_GAP: begin
        grant_n = '0;
        if (gap_cnt == '0) begin
          if (req[cur_src]) begin
            take = 1'b1;
            tgt  = cur_src;
          end else if (|req) begin
            take = 1'b1;
            tgt  = nxt_src;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
`endif

      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase

    if (take) begin
      state_n = S_SHOW;
      cur_n   = tgt;
      grant_n = onehot(tgt);
      rr_n    = inc(tgt);
      dwell_n = DWELL_W'(DWELL - 1);
      pulse_n = 1'b1;
      mode_n  = src_mode[tgt];
      data_n  = src_data[{tgt, 6'd0} +: 64];
    end
  end

  // State and output registers; reset drives a blank display with no owner.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cur_src      <= '0;
      grant        <= '0;
      rr_ptr       <= '0;
      dwell_cnt    <= '0;
      switch_pulse <= 1'b0;
      disp_mode    <= 1'b1;
      disp_data    <= BLANK;
`ifdef SEG7_SCHED_GAP_EN
      gap_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      cur_src      <= cur_n;
      grant        <= grant_n;
      rr_ptr       <= rr_n;
      dwell_cnt    <= dwell_n;
      switch_pulse <= pulse_n;
      disp_mode    <= mode_n;
      disp_data    <= data_n;
`ifdef SEG7_SCHED_GAP_EN
      gap_cnt      <= gap_n;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Directed bench for seg7_disp_sched with NSRC=4, DWELL=8, GAP_CYC=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg7_disp_sched;

  localparam int NSRC = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NSRC-1:0]   req;
  logic [NSRC-1:0]   src_mode;
  logic [NSRC*64-1:0] src_data;
  logic              hold;
  logic [NSRC-1:0]   grant;
  logic [1:0]        cur_src;
  logic              disp_mode;
  logic [63:0]       disp_data;
  logic              switch_pulse;

  logic [63:0] dv [NSRC];
  int total = 0;
  int bad   = 0;

  seg7_disp_sched #(
    .NSRC(NSRC), .DWELL(8), .DWELL_W(4), .GAP_CYC(4)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .src_mode(src_mode),
    .src_data(src_data), .hold(hold), .grant(grant), .cur_src(cur_src),
    .disp_mode(disp_mode), .disp_data(disp_data), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Source idx owns the display; p is the expected switch_pulse.
  task automatic show_chk(input string tag, input int idx, input logic p);
    logic [NSRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    check({tag, ".grant"}, 64'(grant), 64'(oh));
    check({tag, ".cur"},   64'(cur_src), 64'(idx));
    check({tag, ".pulse"}, 64'(switch_pulse), 64'(p));
    check({tag, ".mode"},  64'(disp_mode), 64'(src_mode[idx]));
    check({tag, ".data"},  disp_data, dv[idx]);
  endtask

  task automatic blank_chk(input string tag);
    check({tag, ".grant"}, 64'(grant), 64'd0);
    check({tag, ".pulse"}, 64'(switch_pulse), 64'd0);
    check({tag, ".mode"},  64'(disp_mode), 64'd1);
    check({tag, ".data"},  disp_data, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    dv[0] = 64'h0000_1111_2222_3333;
    dv[1] = 64'h4444_5555_6666_7777;
    dv[2] = 64'h8888_9999_AAAA_BBBB;
    dv[3] = 64'hCCCC_DDDD_EEEE_0F0F;
    src_data = {dv[3], dv[2], dv[1], dv[0]};
    src_mode = 4'b1010;
    rstn = 1'b0;
    req  = '0;
    hold = 1'b0;
    repeat (2) tick();
    blank_chk("reset");
    check("reset.cur", 64'(cur_src), 64'd0);

`ifdef SEG7_SCHED_GAP_EN
    // Two requesters: 8 owner cycles then 4 blank cycles, alternating.
    rstn = 1'b1;
    req  = 4'b0011;
    for (int c = 0; c < 30; c++) begin
      tick();
      if ((c % 12) < 8) show_chk("gap_own", (c / 12) % 2, (c % 12) == 0);
      else              blank_chk("gap_blank");
    end
`else
    // First grant from IDLE, then reset while showing.
    rstn = 1'b1;
    req  = 4'b0010;
    tick();
    show_chk("first", 1, 1'b1);
    tick();
    show_chk("first_stay", 1, 1'b0);
    rstn = 1'b0;
    #1;
    blank_chk("async_rst");
    tick();
    blank_chk("rst_cycle");
    rstn = 1'b1;
    tick();
    show_chk("rel", 1, 1'b1);

    // Fresh reset, then 0 and 2 alternate every 8 cycles.
    rstn = 1'b0;
    req  = 4'b0101;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      show_chk("rr", ((c / 8) % 2) ? 2 : 0, (c % 8) == 0);
    end

    // Live data of the owner follows one cycle late.
    dv[0] = 64'hDEAD_BEEF_0123_4567;
    src_data[63:0] = dv[0];
    tick();
    show_chk("live", 0, 1'b0);

    // Owner 0 drops mid-dwell; 2 takes over with a full dwell.
    req = 4'b0100;
    tick();
    show_chk("drop", 2, 1'b1);
    req = 4'b0101;
    for (int c = 0; c < 7; c++) begin
      tick();
      show_chk("reload", 2, 1'b0);
    end
    tick();
    show_chk("reload_sw", 0, 1'b1);

    // Only 1 requesting: stays past expiry.
    req = 4'b0010;
    tick();
    show_chk("to1", 1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      tick();
      show_chk("solo", 1, 1'b0);
    end
    // Hold freezes rotation at expiry even with 3 requesting.
    hold = 1'b1;
    req  = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      show_chk("hold", 1, 1'b0);
    end
    hold = 1'b0;
    tick();
    show_chk("unhold", 3, 1'b1);
    // Hold does not block the request-drop rule.
    hold = 1'b1;
    req  = 4'b0010;
    tick();
    show_chk("hold_drop", 1, 1'b1);
    hold = 1'b0;

    // All drop -> blank; resume from rr_ptr (2), not index 0.
    req = '0;
    tick();
    blank_chk("idle");
    tick();
    blank_chk("idle2");
    req = 4'b1111;
    tick();
    show_chk("resume", 2, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_disp_sched.md
Name: seg7_disp_sched

Overview:
- Round-robin scheduler that shares the single 8-digit seven-segment display driver among NSRC requesters (e.g. register dump, PC, switch echo, graphic banner).
- Each requester supplies a display mode (0 = hex text, 1 = raw segment graphic) and 64-bit data.
- The scheduler grants one requester at a time for a minimum dwell period, then rotates.
- Its outputs drive the display driver's disp_mode and i_data inputs directly.

Parameters:
- NSRC, 4: number of requesters, 2..8.
- DWELL, 10_000_000: minimum cycles a granted source stays on the display; must be at least 1.
- DWELL_W, 24: width of the dwell counter; DWELL-1 must fit.
- GAP_CYC, 1_000_000: blank cycles between sources; used only with the optional feature; must be at least 1.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  NSRC  per-source display request, level-held while the source wants the display.
- src_mode  in  NSRC  per-source mode bit: 0 = text, 1 = graphic.
- src_data  in  NSRC*64  per-source data; source i occupies bits [64*i+63:64*i].
- hold  in  1  freezes rotation at dwell expiry; has no effect on the request-drop rule.
- grant  out  NSRC  one-hot current owner; all zero when no source owns the display.
- cur_src  out  clog2(NSRC)  index of the current owner.
- disp_mode  out  1  mode bit to the display driver.
- disp_data  out  64  data to the display driver.
- switch_pulse  out  1  one-cycle pulse on every new grant.

Behaviour:
- Clock and reset: clk; reset rstn, asynchronous, active-low.
- Reset values: state IDLE, grant=0, cur_src=0, rr_ptr=0, dwell_cnt=0, switch_pulse=0, disp_mode=1, disp_data=64'hFFFF_FFFF_FFFF_FFFF (active-low segments, so the display is blank).
- Reset asserted in any state returns all of the above immediately.
- Arbitration function pick(start): the first index i with req[i]=1, searching start, start+1, ... with wrap modulo NSRC.
- IDLE:
  - Outputs hold the blank values.
  - If |req at edge t: at edge t+1 set state=SHOW, cur_src=pick(rr_ptr), grant=onehot(cur_src), dwell_cnt=DWELL-1, and switch_pulse=1 for that one cycle.
  - On that same edge, disp_mode and disp_data load the new source's inputs. Latency from req to data on the driver is one cycle.
- SHOW:
  - Every edge, disp_mode<=src_mode[cur_src] and disp_data<=src_data[cur_src]. Live data is tracked with one-cycle latency.
  - dwell_cnt decrements by 1 per cycle and saturates at 0.
- SHOW, owner drops req (req[cur_src]=0), regardless of dwell or hold:
  - Others requesting: grant pick(cur_src+1) next edge.
  - No others: go to IDLE, grant=0, blank outputs.
- SHOW, dwell_cnt==0, hold=0, and some other source requesting: switch to pick(cur_src+1), reload dwell_cnt, pulse switch_pulse.
- SHOW, dwell_cnt==0 and only the owner requesting: remain in SHOW with the counter at 0. A new request then switches on the next edge.
- SHOW, dwell_cnt==0 and hold=1: remain in SHOW indefinitely while the owner keeps requesting.
- rr_ptr update: on every grant to source k, rr_ptr<=k+1 mod NSRC. The search start in IDLE is therefore fair across idle periods.
- Switching to the same source never occurs; no switch_pulse is issued without an owner change.
- grant is always one-hot or zero and always matches cur_src when nonzero.

Optional Feature:
- Macro: SEG7_SCHED_GAP_EN.
- Defined:
  - Every owner-to-owner switch passes through a GAP state for GAP_CYC cycles, with grant=0 and blank outputs (disp_mode=1, data all FF). The next owner is chosen at gap entry.
  - At gap end, if the chosen source still requests, enter SHOW with it. switch_pulse fires at gap end, when the new grant is issued.
  - If the chosen source has dropped, re-arbitrate with pick(chosen+1). If nothing is requesting, go to IDLE.
  - Entry from IDLE has no gap.
- Undefined: no GAP state; switches are direct, as described in Behaviour.

Test Plan:
- Reset mid-SHOW with req=4'b0010 → next cycle grant=0, disp_data=all FF, disp_mode=1. After release, grant=4'b0010 one cycle after the first edge.
- DWELL=8, req=4'b0101 constant → grant alternates 0001/0100 every 8 cycles, one switch_pulse per change, and disp_data follows the owner's data one cycle late.
- Owner 0 drops req at cycle 3 of dwell with req[2]=1 → grant=4'b0100 on the next edge, counter reloaded to 7.
- Only req[1] active, dwell expired; req[3] asserts → grant=4'b1000 on the next edge. With hold=1 instead, grant stays 4'b0010.
- All req drop → IDLE, blank outputs. Then req=4'b1111 → grant continues from rr_ptr, not index 0.
- With SEG7_SCHED_GAP_EN, GAP_CYC=4, req=4'b0011 → 4 blank cycles with grant=0 between each 8-cycle owner period, and switch_pulse at gap end.
